id_front: RTL and testbench

ID_FRONT -- requirements
Module: id_front

---
 rtl/mips_pkg.sv | 42 ++++
 rtl/hazard_unit.sv | 36 +++
 rtl/id_front.sv | 81 ++++++++
 tb/tb_id_front.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings and a small instruction decoder used by the ID front end.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       is_jr;
    logic       uses_rt;
  } decode_t;

  // rt is a true source only for R-type, branches and stores; for loads and
  // immediates it is a destination and must not trigger a load-use stall.
  function automatic decode_t decode(input logic [5:0] opcode, input logic [5:0] funct,
                                     input logic [4:0] rs, input logic [4:0] rt);
    decode_t d;
    d.rs      = rs;
    d.rt      = rt;
    d.is_beq  = (opcode == OP_BEQ);
    d.is_bne  = (opcode == OP_BNE);
    d.is_j    = (opcode == OP_J) || (opcode == OP_JAL);
    d.is_jr   = (opcode == OP_RTYPE) && (funct == FUNCT_JR);
    d.uses_rt = (opcode == OP_RTYPE) || d.is_beq || d.is_bne ||
                (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
    return d;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use and branch-operand hazard detection for the instruction in ID.
module hazard_unit (
  input  logic       valid_id,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  input  logic       is_branch,
  input  logic       is_jr,
  input  logic       reg_write_ex,
  input  logic       mem_read_ex,
  input  logic [4:0] write_reg_ex,
  input  logic       mem_read_mem,
  input  logic [4:0] write_reg_mem,
  output logic       hazard
);

  logic ex_hits_rs, ex_hits_rt, mem_hits_rs, mem_hits_rt;
  logic load_use, branch_op;

  // $0 is never a real dependency, so a zero destination never matches.
  assign ex_hits_rs  = (write_reg_ex  != 5'd0) && (write_reg_ex  == rs);
  assign ex_hits_rt  = (write_reg_ex  != 5'd0) && (write_reg_ex  == rt);
  assign mem_hits_rs = (write_reg_mem != 5'd0) && (write_reg_mem == rs);
  assign mem_hits_rt = (write_reg_mem != 5'd0) && (write_reg_mem == rt);

  assign load_use = mem_read_ex && (ex_hits_rs || (uses_rt && ex_hits_rt));

  // Branches compare in ID, so they also wait on ALU results in EX and loads in MEM.
  assign branch_op =
      (is_branch && ((reg_write_ex && (ex_hits_rs || ex_hits_rt)) ||
                     (mem_read_mem && (mem_hits_rs || mem_hits_rt)))) ||
      (is_jr     && ((reg_write_ex && ex_hits_rs) || (mem_read_mem && mem_hits_rs)));

  assign hazard = valid_id && (load_use || branch_op);

endmodule

// File: rtl/id_front.sv
// IF/ID pipeline register with hazard stalls and early branch/jump resolution.
module id_front
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction_if,
  input  logic [31:0] NextPC_if,
  input  logic        IF_flush,
  input  logic [31:0] RsData_id,
  input  logic [31:0] RtData_id,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic [4:0]  WriteReg_ex,
  input  logic        MemRead_mem,
  input  logic [4:0]  WriteReg_mem,
  output logic [31:0] Instruction_id,
  output logic [31:0] NextPC_id,
  output logic        Valid_id,
  output logic        PC_IFWrite,
  output logic        Stall,
  output logic        Z,
  output logic        J,
  output logic        JR,
  output logic [31:0] BranchAddr,
  output logic [31:0] JumpAddr,
  output logic [31:0] JrAddr
);

  decode_t dec;
  logic    hazard;
  logic    redirect_ok;
  logic    operands_equal;

  always_ff @(posedge clk) begin
    if (reset) begin
      Instruction_id <= NOP_INSTR;
      NextPC_id      <= 32'd0;
      Valid_id       <= 1'b0;
    end else if (PC_IFWrite) begin
      Instruction_id <= IF_flush ? NOP_INSTR : Instruction_if;
      NextPC_id      <= NextPC_if;
      Valid_id       <= ~IF_flush;
    end
  end

  assign dec = decode(Instruction_id[31:26], Instruction_id[5:0],
                      Instruction_id[25:21], Instruction_id[20:16]);

  hazard_unit u_hazard (
    .valid_id      (Valid_id),
    .rs            (dec.rs),
    .rt            (dec.rt),
    .uses_rt       (dec.uses_rt),
    .is_branch     (dec.is_beq | dec.is_bne),
    .is_jr         (dec.is_jr),
    .reg_write_ex  (RegWrite_ex),
    .mem_read_ex   (MemRead_ex),
    .write_reg_ex  (WriteReg_ex),
    .mem_read_mem  (MemRead_mem),
    .write_reg_mem (WriteReg_mem),
    .hazard        (hazard)
  );

  // Reset masks the stall immediately so the PC keeps moving while reset is held.
  assign Stall       = hazard & ~reset;
  assign PC_IFWrite  = ~Stall;
  assign redirect_ok = Valid_id & ~Stall & ~reset;

  assign operands_equal = (RsData_id == RtData_id);
  assign Z  = redirect_ok & ((dec.is_beq & operands_equal) | (dec.is_bne & ~operands_equal));
  assign J  = redirect_ok & dec.is_j;
  assign JR = redirect_ok & dec.is_jr;

  assign BranchAddr = NextPC_id + {{14{Instruction_id[15]}}, Instruction_id[15:0], 2'b00};
  assign JumpAddr   = {NextPC_id[31:28], Instruction_id[25:0], 2'b00};
  assign JrAddr     = RsData_id;

endmodule

// File: tb/tb_id_front.sv
// Randomized self-checking bench for id_front against a behavioural IF/ID model.
module tb_id_front;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instruction_if, NextPC_if, RsData_id, RtData_id;
  logic        IF_flush, RegWrite_ex, MemRead_ex, MemRead_mem;
  logic [4:0]  WriteReg_ex, WriteReg_mem;
  logic [31:0] Instruction_id, NextPC_id, BranchAddr, JumpAddr, JrAddr;
  logic        Valid_id, PC_IFWrite, Stall, Z, J, JR;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  logic [31:0] m_instr, m_npc;
  logic        m_valid;

  id_front #(.NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .Instruction_if(Instruction_if), .NextPC_if(NextPC_if),
    .IF_flush(IF_flush), .RsData_id(RsData_id), .RtData_id(RtData_id),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .WriteReg_ex(WriteReg_ex),
    .MemRead_mem(MemRead_mem), .WriteReg_mem(WriteReg_mem),
    .Instruction_id(Instruction_id), .NextPC_id(NextPC_id), .Valid_id(Valid_id),
    .PC_IFWrite(PC_IFWrite), .Stall(Stall), .Z(Z), .J(J), .JR(JR),
    .BranchAddr(BranchAddr), .JumpAddr(JumpAddr), .JrAddr(JrAddr)
  );

  always #5 clk = ~clk;

  // Dependency rules evaluated directly on the model's ID instruction fields.
  function automatic bit model_stall();
    int op, fn, rs, rt, wex, wmem;
    bit src_rt, br, jr, lu, bo;
    op = int'(m_instr[31:26]); fn = int'(m_instr[5:0]);
    rs = int'(m_instr[25:21]); rt = int'(m_instr[20:16]);
    wex = int'(WriteReg_ex); wmem = int'(WriteReg_mem);
    br = (op == 4 || op == 5);
    jr = (op == 0 && fn == 8);
    src_rt = (op == 0 || br || op == 40 || op == 41 || op == 43);
    lu = MemRead_ex && wex != 0 && (wex == rs || (src_rt && wex == rt));
    bo = 1'b0;
    if (br)
      bo = (RegWrite_ex && wex != 0 && (wex == rs || wex == rt)) ||
           (MemRead_mem && wmem != 0 && (wmem == rs || wmem == rt));
    if (jr)
      bo = (RegWrite_ex && wex != 0 && wex == rs) || (MemRead_mem && wmem != 0 && wmem == rs);
    return !reset && m_valid && (lu || bo);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
    end else if (!model_stall()) begin
      m_instr = IF_flush ? 32'h0 : Instruction_if;
      m_npc   = NextPC_if;
      m_valid = !IF_flush;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit st, live;
      int op, off;
      st   = model_stall();
      live = !reset && m_valid && !st;
      op   = int'(m_instr[31:26]);
      off  = int'($signed(m_instr[15:0]));
      check_output("m_Instruction_id", Instruction_id, m_instr);
      check_output("m_NextPC_id", NextPC_id, m_npc);
      check_output("m_Valid_id", {31'd0, Valid_id}, {31'd0, m_valid});
      check_output("m_Stall", {31'd0, Stall}, {31'd0, st});
      check_output("m_PC_IFWrite", {31'd0, PC_IFWrite}, {31'd0, !st});
      check_output("m_Z", {31'd0, Z}, {31'd0, live && ((op == 4 && RsData_id == RtData_id) ||
                                                    (op == 5 && RsData_id != RtData_id))});
      check_output("m_J", {31'd0, J}, {31'd0, live && (op == 2 || op == 3)});
      check_output("m_JR", {31'd0, JR}, {31'd0, live && op == 0 && m_instr[5:0] == 6'd8});
      check_output("m_BranchAddr", BranchAddr, m_npc + 32'(off * 4));
      check_output("m_JumpAddr", JumpAddr, (m_npc & 32'hF000_0000) | ({6'd0, m_instr[25:0]} << 2));
      check_output("m_JrAddr", JrAddr, RsData_id);
    end
  end

  task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] npc, input logic flush);
    Instruction_if = instr; NextPC_if = npc; IF_flush = flush;
  endtask

  task automatic set_pipe(input logic rw_ex, input logic mr_ex, input logic [4:0] wr_ex,
                          input logic mr_mem, input logic [4:0] wr_mem);
    RegWrite_ex = rw_ex; MemRead_ex = mr_ex; WriteReg_ex = wr_ex;
    MemRead_mem = mr_mem; WriteReg_mem = wr_mem;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt;
    logic [15:0] imm;
    rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); imm = 16'($urandom);
    case ($urandom_range(0, 7))
      0: return {6'd0, rs, rt, 5'($urandom_range(1, 7)), 5'd0, 6'h20};
      1: return {6'd0, rs, 15'd0, 6'h08};
      2: return {6'd4, rs, rt, imm};
      3: return {6'd5, rs, rt, imm};
      4: return {6'd2, 26'($urandom)};
      5: return {6'd3, 26'($urandom)};
      6: return {6'h23, rs, rt, imm};
      default: return {6'h2B, rs, rt, imm};
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    apply_stimulus(32'h0, 32'h0, 1'b0);
    RsData_id = 32'h0; RtData_id = 32'h0;
    set_pipe(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    step(); step();
    @(negedge clk);
    check_output("rst_Instruction_id", Instruction_id, 32'h0);
    check_output("rst_NextPC_id", NextPC_id, 32'h0);
    check_output("rst_Valid_id", {31'd0, Valid_id}, 32'd0);
    check_output("rst_Stall", {31'd0, Stall}, 32'd0);
    check_output("rst_PC_IFWrite", {31'd0, PC_IFWrite}, 32'd1);
    chk_en = 1'b1;
    reset  = 1'b0;

    apply_stimulus(32'h0000_0020, 32'd4, 1'b0);
    step(); @(negedge clk);
    check_output("fetch_instr", Instruction_id, 32'h0000_0020);
    check_output("fetch_npc", NextPC_id, 32'd4);
    check_output("fetch_valid", {31'd0, Valid_id}, 32'd1);
    check_output("fetch_zjjr", {29'd0, Z, J, JR}, 32'd0);

    apply_stimulus(32'h1022_0003, 32'h10, 1'b0);
    RsData_id = 32'd5; RtData_id = 32'd5;
    step(); @(negedge clk);
    check_output("beq_Z", {31'd0, Z}, 32'd1);
    check_output("beq_addr", BranchAddr, 32'h1C);
    apply_stimulus(32'h0000_0820, 32'h14, 1'b1);
    step(); @(negedge clk);
    check_output("flush_valid", {31'd0, Valid_id}, 32'd0);

    apply_stimulus(32'h0065_2020, 32'h20, 1'b0);
    step();
    set_pipe(1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
    apply_stimulus(32'h0000_0820, 32'h24, 1'b0);
    @(negedge clk);
    check_output("lu_stall", {31'd0, Stall}, 32'd1);
    check_output("lu_pcw", {31'd0, PC_IFWrite}, 32'd0);
    step();
    set_pipe(1'b0, 1'b0, 5'd0, 1'b1, 5'd3);
    @(negedge clk);
    check_output("lu_held", Instruction_id, 32'h0065_2020);
    check_output("lu_release", {31'd0, Stall}, 32'd0);

    apply_stimulus(32'h1060_0001, 32'h40, 1'b0);
    set_pipe(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    set_pipe(1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
    apply_stimulus(32'h0000_0820, 32'h44, 1'b0);
    @(negedge clk);
    check_output("lb_stall1", {31'd0, Stall}, 32'd1);
    step();
    set_pipe(1'b0, 1'b0, 5'd0, 1'b1, 5'd3);
    @(negedge clk);
    check_output("lb_stall2", {31'd0, Stall}, 32'd1);
    step();
    set_pipe(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    RsData_id = 32'd0; RtData_id = 32'd0;
    @(negedge clk);
    check_output("lb_done", {31'd0, Stall}, 32'd0);
    check_output("lb_Z", {31'd0, Z}, 32'd1);
    check_output("lb_addr", BranchAddr, 32'h44);

    apply_stimulus(32'h0800_0040, 32'hF000_0004, 1'b0);
    step(); @(negedge clk);
    check_output("j_J", {31'd0, J}, 32'd1);
    check_output("j_addr", JumpAddr, 32'hF000_0100);
    apply_stimulus(32'h03E0_0008, 32'hF000_0008, 1'b0);
    RsData_id = 32'h44;
    step(); @(negedge clk);
    check_output("jr_JR", {31'd0, JR}, 32'd1);
    check_output("jr_addr", JrAddr, 32'h44);

    apply_stimulus(32'h0000_2020, 32'h60, 1'b0);
    step();
    set_pipe(1'b1, 1'b1, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    check_output("zero_reg_stall", {31'd0, Stall}, 32'd0);

    apply_stimulus(32'h0065_2020, 32'h64, 1'b0);
    set_pipe(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    set_pipe(1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
    @(negedge clk);
    check_output("pre_rst_stall", {31'd0, Stall}, 32'd1);
    reset = 1'b1;
    step(); @(negedge clk);
    check_output("rst_stall_valid", {31'd0, Valid_id}, 32'd0);
    check_output("rst_stall_stall", {31'd0, Stall}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      step();
      reset = ($urandom_range(0, 63) == 0);
      apply_stimulus(rand_instr(), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 4) == 0);
      set_pipe(1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
               1'($urandom), 5'($urandom_range(0, 3)));
      RsData_id = 32'($urandom_range(0, 2));
      RtData_id = 32'($urandom_range(0, 2));
    end
    step(); @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
